// File: rtl/mfi_causal_check_multi_pkg.sv
// Shared types and helpers for the MFI causality checker.
//   causal_state_t : WAIT until the tracked instruction retires, then SEEN (absorbing).
//   lane_lo        : bit offset of lane 'lane' in a flat per-lane bus of field width 'w'.
package mfi_check_pkg;

  typedef enum logic {WAIT = 1'b0, SEEN = 1'b1} causal_state_t;

  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

endpackage

// File: rtl/mfi_causal_check_multi_if.sv
// MFI retirement stream bundle, one flat vector per field, lane i at [i*W +: W].
//   master : driver of the retire stream (core / bench)
//   slave  : observer (the causality checker)
interface mfi_causal_check_multi_if #(
  parameter int NRET    = 1,
  parameter int ORDER_W = 32,
  parameter int REG_W   = 5
);
  logic [NRET-1:0]         mfi_valid;
  logic [NRET*ORDER_W-1:0] mfi_order;
  logic [NRET*REG_W-1:0]   mfi_src1_addr;
  logic [NRET*REG_W-1:0]   mfi_src2_addr;
  logic [NRET*REG_W-1:0]   mfi_dest_addr;

  modport master (output mfi_valid, mfi_order, mfi_src1_addr, mfi_src2_addr, mfi_dest_addr);
  modport slave  (input  mfi_valid, mfi_order, mfi_src1_addr, mfi_src2_addr, mfi_dest_addr);
endinterface

// File: rtl/mfi_causal_check_multi_lane_hit.sv
// Combinational per-lane hit decode: a valid retirement younger than the tracked
// order that reads (or, with MODE_WAW, writes) the tracked register.
//   valid_i/order_i/src1_i/src2_i/dest_i : one lane of the retire stream
//   t_ord_i/t_reg_i                      : tracked order and register
//   hit_o                                : lane is a causality violation candidate
module mfi_lane_hit #(
  parameter int ORDER_W  = 32,
  parameter int REG_W    = 5,
  parameter bit MODE_WAW = 1'b0
) (
  input  logic               valid_i,
  input  logic [ORDER_W-1:0] order_i,
  input  logic [REG_W-1:0]   src1_i,
  input  logic [REG_W-1:0]   src2_i,
  input  logic [REG_W-1:0]   dest_i,
  input  logic [ORDER_W-1:0] t_ord_i,
  input  logic [REG_W-1:0]   t_reg_i,
  output logic               hit_o
);
  logic younger, rd_match, wr_match;

  assign younger  = order_i > t_ord_i;
  assign rd_match = (src1_i == t_reg_i) || (src2_i == t_reg_i);
  assign wr_match = MODE_WAW && (dest_i == t_reg_i);
  assign hit_o    = valid_i && younger && (rd_match || wr_match);
endmodule

// File: rtl/mfi_causal_check_multi.sv
// Causality checker for multi-retire cores. Tracks one instruction (order, dest
// reg, lane); any younger retirement touching that reg before (or in the same
// cycle as) the tracked retirement is counted as a violation.
//   clock, reset    : core clock, async active-high reset
//   check           : tracked instruction retires this cycle
//   mfi             : retire stream (slave modport)
//   cfg_order/reg/lane : tracked triple in simulation, must be held stable
//   found_violation : sticky violation flag
//   target_retired  : sticky, tracked instruction has retired
//   viol_count      : saturating count of violating lane-retirements
module mfi_causal_check_multi
  import mfi_check_pkg::*;
#(
  parameter int NRET     = 1,
  parameter int ORDER_W  = 32,
  parameter int REG_W    = 5,
  parameter bit MODE_WAW = 1'b0,
  parameter int CNT_W    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  check,
  mfi_causal_check_multi_if.slave mfi,
  input  logic [ORDER_W-1:0]    cfg_order,
  input  logic [REG_W-1:0]      cfg_reg,
  input  logic [$clog2(NRET):0] cfg_lane,
  output logic                  found_violation,
  output logic                  target_retired,
  output logic [CNT_W-1:0]      viol_count
);
  localparam int PW    = $clog2(NRET + 1);
  localparam int SUM_W = CNT_W + PW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef FORMAL
  (* anyconst *) logic [ORDER_W-1:0]    t_ord;
  (* anyconst *) logic [REG_W-1:0]      t_reg;
  (* anyconst *) logic [$clog2(NRET):0] t_lane;
  wire unused_cfg = &{1'b0, cfg_order, cfg_reg, cfg_lane};
`else
  logic [ORDER_W-1:0]    t_ord;
  logic [REG_W-1:0]      t_reg;
  logic [$clog2(NRET):0] t_lane;
  assign t_ord  = cfg_order;
  assign t_reg  = cfg_reg;
  assign t_lane = cfg_lane;
  // lane only matters for the check-cycle assumptions
  wire unused_lane = &{1'b0, t_lane};
`endif

  logic [NRET-1:0] hit;

  for (genvar i = 0; i < NRET; i++) begin : g_lane
    mfi_lane_hit #(.ORDER_W(ORDER_W), .REG_W(REG_W), .MODE_WAW(MODE_WAW)) u_hit (
      .valid_i (mfi.mfi_valid[i]),
      .order_i (mfi.mfi_order[lane_lo(i, ORDER_W) +: ORDER_W]),
      .src1_i  (mfi.mfi_src1_addr[lane_lo(i, REG_W) +: REG_W]),
      .src2_i  (mfi.mfi_src2_addr[lane_lo(i, REG_W) +: REG_W]),
      .dest_i  (mfi.mfi_dest_addr[lane_lo(i, REG_W) +: REG_W]),
      .t_ord_i (t_ord),
      .t_reg_i (t_reg),
      .hit_o   (hit[i])
    );
  end

  causal_state_t    state_q, state_d;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pop;
  logic [SUM_W-1:0] sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NRET; i++) pop = pop + PW'(hit[i]);
  end

  assign sum = SUM_W'(cnt_q) + SUM_W'(pop);

  always_comb begin
    state_d = state_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;
    // hits in the check cycle itself still count: a younger op retiring
    // alongside the writer has not observed its result
    if (state_q == WAIT) begin
      if (pop != '0) flag_d = 1'b1;
      cnt_d = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
      if (check) state_d = SEEN;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= WAIT;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign found_violation = flag_q;
  assign target_retired  = (state_q == SEEN);
  assign viol_count      = cnt_q;

`ifdef FORMAL
  always_comb begin
    if (!reset && check) begin
      assume (t_reg != '0);
      assume (t_lane < NRET);
      assume (mfi.mfi_valid[t_lane]);
      assume (mfi.mfi_dest_addr[t_lane*REG_W +: REG_W] == t_reg);
      assume (mfi.mfi_order[t_lane*ORDER_W +: ORDER_W] == t_ord);
      assert (!found_violation);
    end
    assert (found_violation == (viol_count != '0));
  end

  always @(posedge clock) cover (!reset && check && (&mfi.mfi_valid));
`endif
endmodule
